// File: rtl/rr_arbiter4x16_pkg.sv
// Shared constants and the round-robin pick function for rr_arbiter4x16.
package rr_arbiter4x16_pkg;
    localparam int NREQ = 4;
    localparam int DW   = 16;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_OWN  = 1'b1;

    // First set bit of req searching upward from ptr, modulo NREQ.
    // Walks the offsets from high to low so the nearest set bit is written last.
    function automatic logic [1:0] rr_winner(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_winner = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_winner = idx;
        end
    endfunction
endpackage

// File: rtl/rr_arbiter4x16_if.sv
// Requester-side bus of the 4x16 round-robin arbiter.
interface rr_arbiter4x16_if;
    import rr_arbiter4x16_pkg::*;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   i0, i1, i2, i3;
    logic [NREQ-1:0] gnt;
    logic [1:0]      sel;
    logic [DW-1:0]   out;
    logic            valid;

    modport master (output req, i0, i1, i2, i3, input gnt, sel, out, valid);
    modport slave  (input req, i0, i1, i2, i3, output gnt, sel, out, valid);
endinterface

// File: rtl/rr_arbiter4x16_mux.sv
// Unmasked 4-way data steering; the caller applies any valid gating.
module mux4way16
    import rr_arbiter4x16_pkg::*;
(
    input  logic [1:0]               sel,
    input  logic [NREQ-1:0][DW-1:0]  d,
    output logic [DW-1:0]            y
);
    assign y = d[sel];
endmodule

// File: rtl/rr_arbiter4x16.sv
// Round-robin arbiter for four 16-bit requesters with registered one-hot grant.
// Define RR_ARBITER_TIMEOUT_EN to compile in the MAX_HOLD forced rotation.
module rr_arbiter4x16
    import rr_arbiter4x16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter4x16_if.slave bus
);
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    logic [0:0]      state;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      sel_q;
    logic [1:0]      ptr;
    logic [NREQ-1:0] others;
    logic [1:0]      win;
    logic            grant_en;
    logic            drop;
    logic [DW-1:0]   mux_y;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt;
`endif

    // The owner is masked out, so the same pick serves idle grant, release and timeout.
    assign others = bus.req & ~gnt_q;
    assign win    = rr_winner(others, ptr);

    always_comb begin
        grant_en = 1'b0;
        drop     = 1'b0;
        if (state == ARB_IDLE) begin
            grant_en = |bus.req;
        end else if (!bus.req[sel_q]) begin
            grant_en = |others;
            drop     = ~|others;
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        else if (cnt == HOLD_LAST) begin
            grant_en = |others;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            gnt_q <= '0;
            sel_q <= '0;
            ptr   <= '0;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else if (grant_en) begin
            state <= ARB_OWN;
            gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            sel_q <= win;
            ptr   <= win + 2'd1;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else if (drop) begin
            // sel keeps the last owner while idle
            state <= ARB_IDLE;
            gnt_q <= '0;
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        else if (state == ARB_OWN && cnt != HOLD_LAST) begin
            cnt <= cnt + 8'd1;
        end
`endif
    end

    mux4way16 u_mux (
        .sel (sel_q),
        .d   ({bus.i3, bus.i2, bus.i1, bus.i0}),
        .y   (mux_y)
    );

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = |gnt_q;
    assign bus.out   = mux_y & {DW{|gnt_q}};
endmodule

// File: tb/tb_rr_arbiter4x16.sv
// Directed bench for rr_arbiter4x16 with a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter4x16;
    localparam int MH = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rr_arbiter4x16_if bus();
    rr_arbiter4x16 #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // model: current owner (-1 idle), last owner index, next search start, cycles held
    int m_own = -1, m_sel = 0, m_ptr = 0, m_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [15:0] data_of(input int k);
        case (k)
            0: return bus.i0;
            1: return bus.i1;
            2: return bus.i2;
            default: return bus.i3;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [3:0] oth;
        int w;
        if (reset) begin
            m_own = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            oth = bus.req;
            if (m_own >= 0) oth[m_own] = 1'b0;
            w = pick(oth, m_ptr);
            if (m_own < 0 || !bus.req[m_own] || (TMO && m_cnt == MH - 1)) begin
                if (w >= 0) begin
                    m_own = w; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
                end else if (m_own >= 0 && !bus.req[m_own]) begin
                    m_own = -1;
                end
            end else if (TMO) begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_gnt", 32'(bus.gnt), (m_own < 0) ? 32'h0 : (32'h1 << m_own));
            check("mdl_sel", 32'(bus.sel), 32'(m_sel));
            check("mdl_valid", 32'(bus.valid), (m_own >= 0) ? 32'h1 : 32'h0);
            check("mdl_out", 32'(bus.out), (m_own < 0) ? 32'h0 : 32'(data_of(m_own)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [3:0] vec [0:15] = '{4'b0000, 4'b1010, 4'b1010, 4'b0010, 4'b0110, 4'b0100,
                               4'b1101, 4'b1001, 4'b0001, 4'b1111, 4'b0111, 4'b0011,
                               4'b1000, 4'b0000, 4'b0101, 4'b1111};

    initial begin
        bus.req = 4'b0000;
        bus.i0 = 16'h1111; bus.i1 = 16'h2222; bus.i2 = 16'hBEEF; bus.i3 = 16'h3333;
        cyc(2);
        chk_en = 1'b1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_out", 32'(bus.out), 32'h0);

        reset = 1'b0; bus.req = 4'b0100; cyc();
        check("t1_gnt", 32'(bus.gnt), 32'b0100);
        check("t1_sel", 32'(bus.sel), 32'd2);
        check("t1_out", 32'(bus.out), 32'hBEEF);
        check("t1_valid", 32'(bus.valid), 32'h1);
        bus.req = 4'b0000; cyc();
        check("idle_gnt", 32'(bus.gnt), 32'h0);
        check("idle_out", 32'(bus.out), 32'h0);
        check("idle_sel_hold", 32'(bus.sel), 32'd2);

        // all four requesting from reset, each owner drops in turn
        reset = 1'b1; bus.req = 4'b1111; cyc();
        reset = 1'b0; cyc();
        check("rr_g0", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b1110; cyc(); check("rr_g1", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b1100; cyc(); check("rr_g2", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b1000; cyc(); check("rr_g3", 32'(bus.gnt), 32'b1000);
        bus.req = 4'b0111; cyc(); check("rr_wrap0", 32'(bus.gnt), 32'b0001);
        check("rr_wrap0_out", 32'(bus.out), 32'h1111);

        // owner 3 releases with only requester 0 waiting and ptr at 0
        bus.req = 4'b0000; cyc();
        bus.req = 4'b1000; cyc(); check("o3_gnt", 32'(bus.gnt), 32'b1000);
        bus.req = 4'b0001; cyc();
        check("o3_handoff", 32'(bus.gnt), 32'b0001);
        check("o3_handoff_valid", 32'(bus.valid), 32'h1);

        // two requesters held: alternate every MH cycles with timeout, else owner 0 keeps it
        reset = 1'b1; bus.req = 4'b0000; cyc();
        reset = 1'b0; bus.req = 4'b0011; cyc();
        for (int k = 0; k < 12; k++) begin
            check("hold2_gnt", 32'(bus.gnt), (TMO && ((k / MH) % 2 == 1)) ? 32'b0010 : 32'b0001);
            cyc();
        end

        // single requester never loses the bus
        reset = 1'b1; bus.req = 4'b0000; cyc();
        reset = 1'b0; bus.req = 4'b0001; cyc();
        for (int k = 0; k < 12; k++) begin
            check("hold1_gnt", 32'(bus.gnt), 32'b0001);
            cyc();
        end

        // reset in the middle of a grant to requester 1
        reset = 1'b1; bus.req = 4'b0000; cyc();
        reset = 1'b0; bus.req = 4'b0010; cyc();
        check("mid_pre_gnt", 32'(bus.gnt), 32'b0010);
        reset = 1'b1; bus.req = 4'b1111; cyc();
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        check("mid_rst_out", 32'(bus.out), 32'h0);
        check("mid_rst_valid", 32'(bus.valid), 32'h0);
        reset = 1'b0; cyc();
        check("mid_after_gnt", 32'(bus.gnt), 32'b0001);

        // mixed vector sweep, checked by the model each cycle
        for (int k = 0; k < 16; k++) begin
            bus.req = vec[k];
            bus.i0 = 16'h0A00 + 16'(k); bus.i3 = 16'hF000 ^ 16'(k);
            cyc();
        end
        bus.req = 4'b0000; cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
